// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared types and constants for the display datapath
//                (binary-to-BCD conversion feeding 7-segment decoders).
//  Contents    : BCD_DIGIT_W  - width of one BCD nibble
//                BCD_BLANK    - nibble code the decoders render as all-off
//                bcd_state_t  - converter FSM state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } bcd_state_t;

endpackage : display_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adj
//  Description : Double-dabble digit correction. Adds 3 to a BCD nibble when
//                it is 5 or more, so that the following left shift carries
//                correctly into the next decimal digit. Purely combinational.
//  Ports       : digit_in  [3:0] - scratch nibble before correction
//                digit_out [3:0] - corrected nibble (never above 4'hC)
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import display_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_converter
//  Description : Sequential binary-to-BCD converter (shift-and-add-3).
//                One binary bit is consumed per cycle; a conversion takes
//                BIN_W+1 cycles from accepted start to the done pulse.
//                Results wider than DIGITS digits are reported via overflow
//                and the output holds the value modulo 10^DIGITS.
//  Config      : BCD_LEADING_ZERO_BLANK_EN - when defined, zero digits above
//                the most significant nonzero digit are replaced by 4'hF
//                (digit 0 is never blanked).
//  Parameters  : BIN_W  - binary input width (>= 4)
//                DIGITS - number of BCD digits (>= 1)
//  Ports       : clk      - clock, rising edge
//                rst_n    - asynchronous active-low reset
//                start    - conversion request, sampled only in IDLE
//                bin_in   - unsigned value, captured with accepted start
//                busy     - conversion in progress
//                done     - one-cycle pulse, bcd_out/overflow updated
//                bcd_out  - digit i at [4i+3:4i], digit 0 least significant
//                overflow - last result did not fit in DIGITS digits
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_converter
    import display_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          overflow
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(BIN_W - 1);

    bcd_state_t        r_state;
    bcd_state_t        w_state_next;

    logic [CNT_W-1:0]  r_shift_cnt;
    logic [BIN_W-1:0]  r_bin;
    logic [BCD_W-1:0]  r_scratch;
    logic              r_ovf_scratch;

    logic              r_busy;
    logic              r_done;
    logic [BCD_W-1:0]  r_bcd_out;
    logic              r_overflow;

    logic [BCD_W-1:0]  w_adj;
    logic [BCD_W-1:0]  w_result;

    // ------------------------------------------------------------------------
    // Per-digit add-3 correction applied to the scratch before each shift
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_adj
            bcd_digit_adj u_adj (
                .digit_in  (r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_out (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Final formatting of the scratch into the display value
    // ------------------------------------------------------------------------
`ifdef BCD_LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; while every digit seen so far is zero it
    // is a leading zero and gets blanked. Digit 0 is always shown.
    always_comb begin
        logic w_leading;
        w_leading = 1'b1;
        w_result  = r_scratch;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (w_leading && (r_scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0)) begin
                w_result[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_BLANK;
            end else begin
                w_leading = 1'b0;
            end
        end
    end
`else
    assign w_result = r_scratch;
`endif

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_shift_cnt == '0) begin
                    w_state_next = FINISH;
                end
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath, counter and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_cnt   <= '0;
            r_bin         <= '0;
            r_scratch     <= '0;
            r_ovf_scratch <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_bcd_out     <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin         <= bin_in;
                        r_scratch     <= '0;
                        r_shift_cnt   <= C_CNT_LOAD;
                        r_ovf_scratch <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                SHIFT: begin
                    // {scratch, binary} shifted left by one after correction;
                    // the bit leaving the top digit marks an overflow.
                    r_scratch     <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
                    r_bin         <= {r_bin[BIN_W-2:0], 1'b0};
                    r_ovf_scratch <= r_ovf_scratch | w_adj[BCD_W-1];
                    if (r_shift_cnt != '0) begin
                        r_shift_cnt <= r_shift_cnt - 1'b1;
                    end
                end
                FINISH: begin
                    r_bcd_out  <= w_result;
                    r_overflow <= r_ovf_scratch;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd_out  = r_bcd_out;
    assign overflow = r_overflow;

endmodule : bcd_converter
`default_nettype wire

// File: tb/tb_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_converter
//  Description : Directed self-checking bench for bcd_converter. One instance
//                uses the default 16-bit/5-digit configuration, a second uses
//                3 digits to exercise overflow. Expected values are hand
//                computed and follow BCD_LEADING_ZERO_BLANK_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_converter;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [19:0] E_1234  = 20'hF1234;
    localparam logic [19:0] E_0     = 20'hFFFF0;
    localparam logic [19:0] E_42    = 20'hFFF42;
    localparam logic [19:0] E_7     = 20'hFFFF7;
    localparam logic [19:0] E_100   = 20'hFF100;
    localparam logic [19:0] E_321   = 20'hFF321;
    localparam logic [11:0] E3_1000 = 12'hFF0;
`else
    localparam logic [19:0] E_1234  = 20'h01234;
    localparam logic [19:0] E_0     = 20'h00000;
    localparam logic [19:0] E_42    = 20'h00042;
    localparam logic [19:0] E_7     = 20'h00007;
    localparam logic [19:0] E_100   = 20'h00100;
    localparam logic [19:0] E_321   = 20'h00321;
    localparam logic [11:0] E3_1000 = 12'h000;
`endif
    localparam logic [19:0] E_65535 = 20'h65535;
    localparam logic [11:0] E3_999  = 12'h999;

    logic        clk;
    logic        rst_n;
    logic        start5, start3;
    logic [15:0] bin5, bin3;
    logic        busy5, done5, ovf5;
    logic        busy3, done3, ovf3;
    logic [19:0] bcd5;
    logic [11:0] bcd3;

    int vectors;
    int miscompares;

    bcd_converter #(.BIN_W(16), .DIGITS(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start5),
        .bin_in   (bin5),
        .busy     (busy5),
        .done     (done5),
        .bcd_out  (bcd5),
        .overflow (ovf5)
    );

    bcd_converter #(.BIN_W(16), .DIGITS(3)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start3),
        .bin_in   (bin3),
        .busy     (busy3),
        .done     (done3),
        .bcd_out  (bcd3),
        .overflow (ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start on the 5-digit instance; returns 1 after accepting edge.
    task automatic pulse5(input logic [15:0] value);
        @(negedge clk);
        bin5   = value;
        start5 = 1'b1;
        @(posedge clk);
        #1;
        start5 = 1'b0;
    endtask

    task automatic pulse3(input logic [15:0] value);
        @(negedge clk);
        bin3   = value;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
    endtask

    // Counts cycles until done (bounded), and cycles with busy high,
    // including the sample just after the accepting edge.
    task automatic wait_done5(output int cycles, output int busy_cycles);
        busy_cycles = busy5 ? 1 : 0;
        cycles      = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done5) break;
            if (busy5) busy_cycles++;
        end
    endtask

    task automatic wait_done3(output int cycles);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done3) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy5, done5, ovf5, bcd5} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset5: got busy=%b done=%b ovf=%b bcd=%h, want all 0",
                     busy5, done5, ovf5, bcd5);
        end
        vectors++;
        if ({busy3, done3, ovf3, bcd3} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset3: got busy=%b done=%b ovf=%b bcd=%h, want all 0",
                     busy3, done3, ovf3, bcd3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_1234;
        int cyc, bcyc;
        pulse5(16'd1234);
        wait_done5(cyc, bcyc);
        vectors++;
        if (cyc !== 17) begin
            miscompares++;
            $display("FAIL latency_1234: got %0d cycles, want 17", cyc);
        end
        vectors++;
        if (bcyc !== 17) begin
            miscompares++;
            $display("FAIL busy_len_1234: got %0d cycles, want 17", bcyc);
        end
        vectors++;
        if (busy5 !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_at_done: got %b, want 0", busy5);
        end
        vectors++;
        if (bcd5 !== E_1234 || ovf5 !== 1'b0) begin
            miscompares++;
            $display("FAIL value_1234: got bcd=%h ovf=%b, want bcd=%h ovf=0", bcd5, ovf5, E_1234);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done5 !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width: got done=%b one cycle later, want 0", done5);
        end
    endtask

    task automatic test_zero_max;
        int cyc, bcyc;
        pulse5(16'd0);
        wait_done5(cyc, bcyc);
        vectors++;
        if (cyc !== 17 || bcd5 !== E_0 || ovf5 !== 1'b0) begin
            miscompares++;
            $display("FAIL value_0: got cyc=%0d bcd=%h ovf=%b, want cyc=17 bcd=%h ovf=0",
                     cyc, bcd5, ovf5, E_0);
        end
        pulse5(16'd65535);
        wait_done5(cyc, bcyc);
        vectors++;
        if (cyc !== 17 || bcd5 !== E_65535 || ovf5 !== 1'b0) begin
            miscompares++;
            $display("FAIL value_65535: got cyc=%0d bcd=%h ovf=%b, want cyc=17 bcd=%h ovf=0",
                     cyc, bcd5, ovf5, E_65535);
        end
    endtask

    task automatic test_overflow;
        int cyc;
        pulse3(16'd1000);
        wait_done3(cyc);
        vectors++;
        if (cyc !== 17 || bcd3 !== E3_1000 || ovf3 !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_1000: got cyc=%0d bcd=%h ovf=%b, want cyc=17 bcd=%h ovf=1",
                     cyc, bcd3, ovf3, E3_1000);
        end
        pulse3(16'd999);
        wait_done3(cyc);
        vectors++;
        if (cyc !== 17 || bcd3 !== E3_999 || ovf3 !== 1'b0) begin
            miscompares++;
            $display("FAIL value3_999: got cyc=%0d bcd=%h ovf=%b, want cyc=17 bcd=%h ovf=0",
                     cyc, bcd3, ovf3, E3_999);
        end
    endtask

    task automatic test_start_while_busy;
        int cyc, bcyc, extra;
        pulse5(16'd42);
        repeat (4) @(posedge clk);
        // Second request with a new value while the first is in flight.
        bin5   = 16'd7;
        start5 = 1'b1;
        @(posedge clk);
        #1;
        start5 = 1'b0;
        wait_done5(cyc, bcyc);
        vectors++;
        if (cyc !== 12 || bcd5 !== E_42) begin
            miscompares++;
            $display("FAIL busy_ignore: got cyc=%0d bcd=%h, want cyc=12 bcd=%h", cyc, bcd5, E_42);
        end
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done5) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL busy_no_queue: got %0d extra done pulses, want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bcyc;
        pulse5(16'd100);
        wait_done5(cyc, bcyc);
        vectors++;
        if (cyc !== 17 || bcd5 !== E_100) begin
            miscompares++;
            $display("FAIL value_100: got cyc=%0d bcd=%h, want cyc=17 bcd=%h", cyc, bcd5, E_100);
        end
        // Issue the next request in the done cycle itself.
        bin5   = 16'd7;
        start5 = 1'b1;
        @(posedge clk);
        #1;
        start5 = 1'b0;
        vectors++;
        if (busy5 !== 1'b1 || done5 !== 1'b0 || bcd5 !== E_100) begin
            miscompares++;
            $display("FAIL b2b_accept: got busy=%b done=%b bcd=%h, want busy=1 done=0 bcd=%h",
                     busy5, done5, bcd5, E_100);
        end
        wait_done5(cyc, bcyc);
        vectors++;
        if (cyc !== 17 || bcd5 !== E_7) begin
            miscompares++;
            $display("FAIL b2b_value_7: got cyc=%0d bcd=%h, want cyc=17 bcd=%h", cyc, bcd5, E_7);
        end
    endtask

    task automatic test_reset_mid;
        int cyc, bcyc, dones;
        pulse5(16'd9999);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy5, done5, ovf5, bcd5} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got busy=%b done=%b ovf=%b bcd=%h, want all 0",
                     busy5, done5, ovf5, bcd5);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done5) dones++;
        end
        vectors++;
        if (dones !== 0 || bcd5 !== 20'd0 || busy5 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: got dones=%0d bcd=%h busy=%b, want 0/0/0",
                     dones, bcd5, busy5);
        end
        pulse5(16'd321);
        wait_done5(cyc, bcyc);
        vectors++;
        if (cyc !== 17 || bcd5 !== E_321 || ovf5 !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset_321: got cyc=%0d bcd=%h ovf=%b, want cyc=17 bcd=%h ovf=0",
                     cyc, bcd5, ovf5, E_321);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start5      = 1'b0;
        start3      = 1'b0;
        bin5        = '0;
        bin3        = '0;

        test_reset;
        test_1234;
        test_zero_max;
        test_overflow;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_bcd_converter
`default_nettype wire

// File: doc/bcd_converter.md
# bcd_converter

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the per-digit 7-segment decoders. It takes an unsigned binary value and produces one 4-bit BCD nibble per display digit, each nibble wired straight into one decoder's `hex_digit` input. Optional leading-zero blanking emits code 4'hF, which the decoders render as all segments off.

## Interface
Parameters:
- `BIN_W`, default 16: width of the binary input; minimum 4.
- `DIGITS`, default 5: number of BCD digits produced; minimum 1.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: conversion request; sampled only in IDLE.
- `bin_in`, in, `BIN_W`: unsigned value; captured on the accepted `start` edge.
- `busy`, out, 1: conversion in progress.
- `done`, out, 1: one-cycle pulse; `bcd_out` updated this cycle.
- `bcd_out`, out, `4*DIGITS`: digit i is at bits `[4i+3:4i]`; digit 0 is the least significant.
- `overflow`, out, 1: last result did not fit in `DIGITS` digits.

## Operation
- FSM states: IDLE, SHIFT, FINISH.
- **IDLE**
  - `start`=1 → capture `bin_in` into the shift register, clear the BCD scratch, set `shift_cnt` = `BIN_W`-1, clear the overflow scratch, go to SHIFT.
  - `start`=0 → stay in IDLE.
- **SHIFT**, executed once per cycle:
  - Every scratch digit ≥5 gets +3.
  - Then shift {scratch, binary} left by 1.
  - The bit shifted out of the top digit ORs into the overflow scratch.
  - When `shift_cnt`=0, go to FINISH; otherwise decrement `shift_cnt`.
- **FINISH**
  - Load `bcd_out` from the scratch, with blanking applied if enabled.
  - Load `overflow` from the overflow scratch.
  - Pulse `done`, return to IDLE.
- **Arithmetic**
  - The add-3 is 4-bit; its result never exceeds 4'hC before the shift.
  - On overflow, `bcd_out` holds `bin_in` mod 10^`DIGITS`.
- **`start` while busy**: ignored. The request is not queued, and `bin_in` changes during a conversion have no effect.
- **`start` during the `done` cycle**: the FSM is already in IDLE that cycle, so `start` is accepted. Back-to-back conversions are therefore allowed with no idle gap.
- **Output hold**: `bcd_out` and `overflow` keep their values until the next FINISH. They stay stable while the next conversion runs.
- **Reset, including mid-conversion**:
  - State returns to IDLE; scratch and counter are cleared.
  - `busy`=0, `done`=0, `overflow`=0, `bcd_out`=all zeros.
  - The first conversion after reset proceeds normally.

## Timing
- `start` is accepted at rising edge k.
- `busy`=1 from edge k until edge k+`BIN_W`+1, i.e. for `BIN_W`+1 cycles.
- `done`=1 and new `bcd_out`/`overflow` are valid in the cycle after edge k+`BIN_W`+1, with `busy`=0 in that same cycle.
- Latency from `start` to `done` is `BIN_W`+1 cycles; throughput is one conversion per `BIN_W`+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `BCD_LEADING_ZERO_BLANK_EN`.
- **Defined**: at FINISH, every zero digit above the most significant nonzero digit is replaced by 4'hF. Digit 0 is never blanked, so value 0 gives …FFF0.
- **Undefined**: all digits are output as computed and leading zeros are shown.
- `overflow` behaviour is identical in both builds.

## Structure
- Package `display_pkg` holds:
  - `BCD_BLANK` = 4'hF.
  - The FSM state enum typedef `bcd_state_t` (IDLE, SHIFT, FINISH).
  - `BCD_DIGIT_W` = 4.
- Sub-module `bcd_digit_adj`: combinational add-3-if-≥5 on one nibble, instantiated `DIGITS` times in a generate loop.
- The FSM, counter, shift register and output registers live in `bcd_converter`.

## Test plan
- **Value 1234**: `BIN_W`=16, `DIGITS`=5, `bin_in`=1234, `start` pulse.
  - Without macro: `done` arrives 17 cycles later and `bcd_out`=20'h01234.
  - With macro: `bcd_out`=20'hF1234.
  - In both builds `busy` is high for exactly 17 cycles and `overflow`=0.
- **Zero and maximum**:
  - `bin_in`=0 → 20'h00000 without the macro, 20'hFFFF0 with it.
  - `bin_in`=65535 → 20'h65535 in both builds, `overflow`=0.
- **Overflow**: `DIGITS`=3, `bin_in`=1000 → `bcd_out`=12'h000 (12'hFF0 with macro), `overflow`=1.
  - A following conversion of 999 gives 12'h999 and clears `overflow`.
- **Start while busy**: pulse `start` with 42, then pulse `start` with 7 at cycle 5 → only one `done`, `bcd_out`=42.
  - `start` with 7 asserted in the `done` cycle → accepted, and the next `done` after 17 cycles gives 7.
- **Reset mid-conversion**: assert `rst_n`=0 at cycle 8 of a conversion of 9999.
  - All outputs go to 0 immediately, no `done` pulse appears, and `bcd_out` remains 0.
  - A new conversion of 321 after release gives a correct result.
